// File: rtl/pedestrian_pkg.sv
// pedestrian_pkg: shared state encoding, default timing constants and widths for the pedestrian request unit.
package pedestrian_pkg;
    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] ARMED    = 2'b01;
    localparam logic [1:0] WALKING  = 2'b10;
    localparam logic [1:0] COOLDOWN = 2'b11;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_COOLDOWN_CYCLES = 8;
    localparam int DEF_WALK_COUNT      = 9;
    localparam int CD_W                = 4;
endpackage

// File: rtl/pedestrian_request_unit_debouncer.sv
// button_debouncer: synchronizes the raw button, accepts it after DEBOUNCE_CYCLES stable highs, pulses press once per accepted edge.
module button_debouncer
    import pedestrian_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    logic       sync0, sync1;
    logic [7:0] cnt, cnt_nxt;
    logic       hit;

    // count saturates at the threshold so a held button keeps level high without wrapping
    always_comb begin
        cnt_nxt = !sync1 ? 8'd0 : (cnt == 8'(DEBOUNCE_CYCLES)) ? cnt : cnt + 8'd1;
        hit     = cnt_nxt == 8'(DEBOUNCE_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            cnt   <= 8'd0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
            cnt   <= cnt_nxt;
            level <= hit;
            press <= hit && !level;
        end
    end
endmodule

// File: rtl/pedestrian_request_unit.sv
// pedestrian_request_unit: latches debounced crossing requests toward the controller and drives the kerb-side walk indicators.
module pedestrian_request_unit
    import pedestrian_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int WALK_COUNT      = DEF_WALK_COUNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn,
    input  logic            walk,
    input  logic            halt,
    output logic            x,
    output logic            wait_lamp,
    output logic [CD_W-1:0] countdown,
    output logic            beep,
    output logic            err
);
    logic [1:0]      state, state_nxt;
    logic [7:0]      cool, cool_nxt;
    logic            pend, pend_nxt;
    logic [CD_W-1:0] cd_nxt;
    logic            level, press, pressed;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .level (level),
        .press (press)
    );

    assign pressed = press && level;

    // walk transitions take precedence over cooldown expiry, which takes precedence over a press
    always_comb begin
        state_nxt = state;
        cool_nxt  = cool;
        pend_nxt  = pend;
        cd_nxt    = countdown;
        case (state)
            IDLE: begin
                if (walk) begin
                    state_nxt = WALKING;
                    cd_nxt    = CD_W'(WALK_COUNT);
                end else if (pressed)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (walk) begin
                    state_nxt = WALKING;
                    cd_nxt    = CD_W'(WALK_COUNT);
                end
            end
            WALKING: begin
                if (walk)
                    cd_nxt = (countdown == '0) ? '0 : countdown - 1'b1;
                else begin
                    state_nxt = COOLDOWN;
                    cd_nxt    = '0;
                    cool_nxt  = 8'(COOLDOWN_CYCLES);
                end
                if (pressed)
                    pend_nxt = 1'b1;
            end
            default: begin
                if (walk) begin
                    state_nxt = WALKING;
                    cd_nxt    = CD_W'(WALK_COUNT);
                    pend_nxt  = 1'b0;
                end else begin
                    cool_nxt = cool - 8'd1;
                    if (cool <= 8'd1) begin
                        state_nxt = (pend || pressed) ? ARMED : IDLE;
                        pend_nxt  = 1'b0;
                    end else if (pressed)
                        pend_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cool      <= 8'd0;
            pend      <= 1'b0;
            countdown <= '0;
            x         <= 1'b0;
            wait_lamp <= 1'b0;
            beep      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cool      <= cool_nxt;
            pend      <= pend_nxt;
            countdown <= cd_nxt;
            x         <= state_nxt == ARMED;
            wait_lamp <= (state_nxt == ARMED) || (state_nxt == COOLDOWN && pend_nxt);
            beep      <= state_nxt == WALKING;
            err       <= err || (walk == halt);
        end
    end
endmodule

// File: tb/tb_pedestrian_request_unit.sv
// tb_pedestrian_request_unit: table-driven and sequenced checks of the pedestrian request unit through an expected-output queue.
module tb_pedestrian_request_unit;
    logic       clk = 1'b0;
    logic       reset, btn, walk, halt;
    logic       x, wait_lamp, beep, err;
    logic [3:0] countdown;

    typedef struct {
        logic       r;
        logic       b;
        logic       w;
        logic       h;
        logic [7:0] e;
        string      nm;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    pedestrian_request_unit dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .walk      (walk),
        .halt      (halt),
        .x         (x),
        .wait_lamp (wait_lamp),
        .countdown (countdown),
        .beep      (beep),
        .err       (err)
    );

    function automatic logic [7:0] o(input logic xx, input logic wl, input logic [3:0] cd, input logic b, input logic e);
        return {xx, wl, cd, b, e};
    endfunction

    task automatic add(input int n, input logic r, input logic b, input logic w, input logic h, input logic [7:0] e, input string nm);
        for (int i = 0; i < n; i++) tbl.push_back('{r, b, w, h, e, nm});
    endtask

    task automatic cyc(input logic r, input logic b, input logic w, input logic h, input logic [7:0] e, input string nm);
        logic [7:0] got, want;
        string      n;
        reset = r;
        btn   = b;
        walk  = w;
        halt  = h;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        got  = {x, wait_lamp, countdown, beep, err};
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s @%0t: got x=%b wl=%b cd=%0d beep=%b err=%b, want x=%b wl=%b cd=%0d beep=%b err=%b",
                     n, $time, got[7], got[6], got[5:2], got[1], got[0], want[7], want[6], want[5:2], want[1], want[0]);
        end
    endtask

    initial begin
        logic [7:0] z, ar, pw;
        z  = o(0, 0, 0, 0, 0);
        ar = o(1, 1, 0, 0, 0);
        pw = o(0, 1, 0, 0, 0);
        // reset with button already held, then debounce latency to the request
        add(2, 1, 1, 0, 1, z, "reset_state");
        add(6, 0, 1, 0, 1, z, "debounce_wait");
        add(1, 0, 1, 0, 1, ar, "first_request");
        // full walk cycle
        add(2, 0, 0, 0, 1, ar, "armed_hold");
        add(1, 0, 0, 1, 0, o(0, 0, 9, 1, 0), "walk_cd9");
        add(1, 0, 0, 1, 0, o(0, 0, 8, 1, 0), "walk_cd8");
        add(1, 0, 0, 1, 0, o(0, 0, 7, 1, 0), "walk_cd7");
        add(1, 0, 0, 1, 0, o(0, 0, 6, 1, 0), "walk_cd6");
        add(9, 0, 0, 0, 1, z, "cooldown_to_idle");
        // short glitch must not raise a request
        add(3, 0, 1, 0, 1, z, "glitch_high");
        add(20, 0, 0, 0, 1, z, "glitch_rejected");
        foreach (tbl[i]) cyc(tbl[i].r, tbl[i].b, tbl[i].w, tbl[i].h, tbl[i].e, tbl[i].nm);

        // press during cooldown: lamp on once accepted, request only at expiry
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, z, "press_idle");
        cyc(0, 1, 0, 1, ar, "press_arm");
        cyc(0, 0, 0, 1, ar, "armed_release");
        cyc(0, 0, 1, 0, o(0, 0, 9, 1, 0), "walk2_cd9");
        cyc(0, 0, 1, 0, o(0, 0, 8, 1, 0), "walk2_cd8");
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, z, "cool_before_press");
        cyc(0, 1, 0, 1, pw, "cool_press_lamp");
        cyc(0, 1, 0, 1, pw, "cool_press_wait");
        cyc(0, 1, 0, 1, ar, "cool_expiry_arm");

        // held button across a whole walk and cooldown issues no second request
        cyc(0, 1, 1, 0, o(0, 0, 9, 1, 0), "held_walk_cd9");
        cyc(0, 1, 1, 0, o(0, 0, 8, 1, 0), "held_walk_cd8");
        for (int i = 0; i < 13; i++) cyc(0, 1, 0, 1, z, "held_no_rearm");

        // unrequested walk, countdown saturation, press during walk becomes pending
        cyc(0, 0, 0, 1, z, "release1");
        cyc(0, 0, 0, 1, z, "release2");
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, o(0, 0, 4'(i < 10 ? 9 - i : 0), 1, 0), "free_walk_cd");
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, pw, "walk_press_pending");
        cyc(0, 1, 0, 1, ar, "pending_arm");

        // protocol errors and reset mid-walk
        cyc(0, 1, 1, 1, o(0, 0, 9, 1, 1), "walk_halt_err");
        cyc(0, 1, 1, 0, o(0, 0, 8, 1, 1), "err_sticky");
        cyc(1, 1, 1, 0, z, "reset_mid_walk");
        cyc(0, 0, 0, 1, z, "post_reset1");
        cyc(0, 0, 0, 1, z, "post_reset2");
        cyc(0, 0, 0, 0, o(0, 0, 0, 0, 1), "neither_err");
        cyc(0, 0, 0, 1, o(0, 0, 0, 0, 1), "neither_sticky");
        cyc(1, 0, 0, 1, z, "reset_clears_err");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
